vga_layer_mixer: RTL

- Downstream compositor for all sprite stages: player, fungi, and the centred win banner.
- Takes each stage's on-flag plus its ROM pixel, and the background pixel, and selects one 12-bit colour per pixel by fixed priority with a transparency key.
- Delays sync/blank to stay aligned with ROM read latency; drives the VGA pins with registered outputs.
- Owns the win-banner blink FSM, so the banner flashes for a fixed number of frames and then holds steady.

---
 rtl/vga_layer_mixer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: final sprite compositor in front of the VGA pins.
// Delays flags and syncs to line up with ROM data, picks one colour per pixel
// by fixed layer priority with a transparency key, and owns the win-banner
// blink controller.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no win; banner hidden
// ST_BLINK  | banner toggles every BLINK_FRAMES frames, BLINK_REPS times
// ST_STEADY | blinking finished; banner held visible while win stays set
module vga_layer_mixer #(
  parameter int          ROM_LAT      = 1,
  parameter logic [11:0] KEY_COLOR    = 12'h0F0,
  parameter int          BLINK_FRAMES = 15,
  parameter int          BLINK_REPS   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        win,
  input  logic        player_on,
  input  logic        fungi_on,
  input  logic        win_on,
  input  logic [11:0] player_pixel,
  input  logic [11:0] fungi_pixel,
  input  logic [11:0] win_pixel,
  input  logic [11:0] bg_pixel,
  output logic [11:0] vga_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic [1:0]  banner_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLINK  = 2'd1,
    ST_STEADY = 2'd2
  } banner_t;

  localparam logic [7:0] FRAME_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [4:0] TOGGLE_DONE = 5'(2 * BLINK_REPS);

  // Stage word layout: {valid, hsync, vsync, player_on, fungi_on, win_on}.
  // Syncs are active low, so their idle value is 1.
  localparam logic [5:0] STAGE_RST = 6'b011000;

  logic [5:0]  stage_q [ROM_LAT];
  logic [5:0]  stage_in;
  logic [5:0]  stage_out;
  logic        d_valid, d_hsync, d_vsync, d_player, d_fungi, d_win;

  logic [11:0] rgb_d, rgb_q;
  logic        hsync_q, vsync_q;

  banner_t     state_d, state_q;
  logic        visible_d, visible_q;
  logic [7:0]  frame_cnt_d, frame_cnt_q;
  logic [4:0]  toggle_cnt_d, toggle_cnt_q;
  logic        frame_tick;

  assign stage_in  = {valid, hsync_in, vsync_in, player_on, fungi_on, win_on};
  assign stage_out = stage_q[ROM_LAT-1];
  assign {d_valid, d_hsync, d_vsync, d_player, d_fungi, d_win} = stage_out;

  // Delay line matching the ROM read latency; advances only on pixel ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) stage_q[i] <= STAGE_RST;
    end else if (pix_en) begin
      stage_q[0] <= stage_in;
      for (int i = 1; i < ROM_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // Layer priority: win banner, player, fungi, then background (never keyed).
  always_comb begin
    rgb_d = 12'h000;
    if (!d_valid) begin
      rgb_d = 12'h000;
    end else if (d_win && visible_q && (win_pixel != KEY_COLOR)) begin
      rgb_d = win_pixel;
    end else if (d_player && (player_pixel != KEY_COLOR)) begin
      rgb_d = player_pixel;
    end else if (d_fungi && (fungi_pixel != KEY_COLOR)) begin
      rgb_d = fungi_pixel;
    end else begin
      rgb_d = bg_pixel;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pix_en) begin
      rgb_q   <= rgb_d;
      hsync_q <= d_hsync;
      vsync_q <= d_vsync;
    end
  end

  // Top-left pixel of the undelayed scan marks the frame boundary; the
  // banner only changes here so a frame is never drawn half-on.
  assign frame_tick = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // Banner controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      visible_q    <= 1'b0;
      frame_cnt_q  <= 8'd0;
      toggle_cnt_q <= 5'd0;
    end else begin
      state_q      <= state_d;
      visible_q    <= visible_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
    end
  end

  // Banner next-state: blink for a fixed number of half-periods, then hold.
  always_comb begin
    state_d      = state_q;
    visible_d    = visible_q;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          visible_d = 1'b0;
          if (win) begin
            state_d      = ST_BLINK;
            visible_d    = 1'b1;
            frame_cnt_d  = 8'd0;
            toggle_cnt_d = 5'd0;
          end
        end
        ST_BLINK: begin
          if (!win) begin
            state_d   = ST_IDLE;
            visible_d = 1'b0;
          end else if (frame_cnt_q == FRAME_LAST) begin
            visible_d    = ~visible_q;
            frame_cnt_d  = 8'd0;
            toggle_cnt_d = toggle_cnt_q + 5'd1;
            // An even toggle count means visible has just come back on.
            if ((toggle_cnt_q + 5'd1) == TOGGLE_DONE) state_d = ST_STEADY;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        ST_STEADY: begin
          visible_d = 1'b1;
          if (!win) begin
            state_d   = ST_IDLE;
            visible_d = 1'b0;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          visible_d = 1'b0;
        end
      endcase
    end
  end

  assign vga_rgb      = rgb_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign banner_state = state_q;

endmodule
